audio_sample_pacer: RTL
=======================

AUDIO_SAMPLE_PACER -- requirements
Module: audio_sample_pacer

Interface
REQ-001 SHALL have parameter AUDIO_BIT_WIDTH, default CONFIG::AUDIO_BIT_WIDTH, the sample width in bits.
REQ-002 SHALL have parameter SAMPLE_TICKS, default CONFIG::AUDIO_CLOCK / CONFIG::AUDIO_SAMPLE_RATE (384), the number of clocks per output sample.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, a power of 2 and at least 2.
REQ-004 SHALL have parameter UNDERRUN_ZERO, default 0: 1 = output 0 on underrun; 0 = hold the last sample.
REQ-005 SHALL have port clock_16_934_400, input, 1 bit, the system audio clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_l, input, 1 bit, asynchronous, active-low reset.
REQ-007 SHALL have port in_sample, input, AUDIO_BIT_WIDTH bits, the sample from the synth/mixer.
REQ-008 SHALL have port in_valid, input, 1 bit, indicating in_sample is valid.
REQ-009 SHALL have port in_ready, output, 1 bit, asserted when the FIFO can accept a sample.
REQ-010 SHALL have port audio_out, output, AUDIO_BIT_WIDTH bits, the paced sample sent to the DAC driver.
REQ-011 SHALL have port sample_strobe, output, 1 bit, a one-cycle pulse in the cycle after audio_out updates.
REQ-012 SHALL have port fill_level, output, $clog2(FIFO_DEPTH)+1 bits, the current FIFO occupancy.
REQ-013 SHALL have port underrun, output, 1 bit, a sticky underrun flag.
REQ-014 SHALL have port underrun_clear, input, 1 bit, a synchronous clear for underrun (and for the counter in REQ-032).
REQ-015 SHALL have port underrun_count, output, 16 bits, the underrun statistic defined in REQ-032 and REQ-033.

Function
REQ-016 SHALL accept a push when in_valid and in_ready are both high at a rising edge; the sample is written at the FIFO tail.
REQ-017 SHALL drive in_ready = (fill_level < FIFO_DEPTH) combinationally from registered state, with no dependence on in_valid and no dependence on a pop in the same cycle.
REQ-018 SHALL run a tick counter from 0 to SAMPLE_TICKS-1, wrapping to 0; the sample tick is the cycle with counter == SAMPLE_TICKS-1.
REQ-019 SHALL, at the edge ending a sample tick with the FIFO non-empty, load audio_out from the FIFO head and pop one entry.
REQ-020 SHALL, at the edge ending a sample tick with the FIFO empty, set underrun to 1 and leave the pointers unchanged.
REQ-021 SHALL, on that empty tick, load audio_out with 0 if UNDERRUN_ZERO=1, else hold audio_out unchanged.
REQ-022 SHALL assert sample_strobe for exactly one cycle after every sample tick, whether or not an underrun occurred; the spacing between strobes is exactly SAMPLE_TICKS cycles.
REQ-023 SHALL change audio_out only at sample-tick edges, so it is stable for SAMPLE_TICKS cycles for the downstream I2S sampling.
REQ-024 SHALL handle a simultaneous push and pop on the same edge as net fill_level unchanged, with the data order preserved.
REQ-025 SHALL, when a push arrives to an empty FIFO on a sample tick, flag an underrun; the pushed sample is emitted at the next tick, with no bypass.
REQ-026 SHALL use read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
REQ-027 SHALL keep fill_level in 0..FIFO_DEPTH, never exceeding FIFO_DEPTH and never going below 0.
REQ-028 SHALL give underrun_clear priority over a same-cycle underrun set; the set is lost that cycle.

Reset
REQ-029 SHALL, with reset_l low, asynchronously set audio_out=0, sample_strobe=0, fill_level=0, underrun=0, underrun_count=0, tick counter=0, and both pointers=0.
REQ-030 SHALL, with reset_l low, hold in_ready=1; FIFO storage contents need no reset.
REQ-031 SHALL, when reset is asserted mid-operation, discard all buffered samples; the first tick after release is SAMPLE_TICKS cycles later.

Configuration
REQ-032 SHALL, with AUDIO_PACER_STATS_EN defined, make underrun_count increment by 1 on each empty-FIFO tick, saturating at 16'hFFFF and cleared by underrun_clear.
REQ-033 SHALL, without AUDIO_PACER_STATS_EN, tie underrun_count to 0 and synthesize no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: push 3 samples 0x1111, 0x2222, 0x3333 before the first tick -> audio_out takes each value on successive ticks 384 cycles apart, with sample_strobe following each.
REQ-035 SHALL cover: hold in_valid high with FIFO_DEPTH=8 and no tick -> 8 accepted, in_ready=0 at fill_level 8, and the 9th sample is held until the next pop.
REQ-036 SHALL cover: empty FIFO at a tick with UNDERRUN_ZERO=0 and last sample 0x0ABC -> audio_out stays 0x0ABC and underrun=1; with UNDERRUN_ZERO=1 -> audio_out=0.
REQ-037 SHALL cover: a full FIFO with push attempted on the tick cycle -> push refused, fill goes 8 to 7, and the push is accepted on the next cycle.
REQ-038 SHALL cover: reset_l pulsed low mid-stream with fill 5 -> all outputs at reset values immediately, and the first strobe 385 cycles after release.
REQ-039 SHALL cover: with AUDIO_PACER_STATS_EN, 3 consecutive empty ticks -> underrun_count=3; then underrun_clear -> count=0 and underrun=0.

Source files
------------

// File: rtl/audio_sample_pacer.sv
// audio_sample_pacer
//
// Paces samples from the synth/mixer out to the DAC driver at a fixed rate.
// A small FIFO absorbs bursty input. A free-running tick counter pops one
// sample every SAMPLE_TICKS clocks. On an empty tick the pacer raises a sticky
// underrun flag, and either holds the last sample or outputs zero.
//
// Parameter defaults come from the system audio configuration:
// 16-bit samples and 16.9344 MHz / 44.1 kHz = 384 clocks per sample.
//
// Optional build macro: AUDIO_PACER_STATS_EN
//   When defined, underrun_count is a saturating 16-bit count of empty ticks.
//   When undefined, underrun_count is tied to zero and no counter is built.

module audio_sample_pacer #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int SAMPLE_TICKS    = 16_934_400 / 44_100,
    parameter int FIFO_DEPTH      = 8,
    parameter int UNDERRUN_ZERO   = 0
) (
    input  logic                               clock_16_934_400,
    input  logic                               reset_l,
    input  logic [AUDIO_BIT_WIDTH-1:0]         in_sample,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [AUDIO_BIT_WIDTH-1:0]         audio_out,
    output logic                               sample_strobe,
    output logic [$clog2(FIFO_DEPTH):0]        fill_level,
    output logic                               underrun,
    input  logic                               underrun_clear,
    output logic [15:0]                        underrun_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 1;
    localparam int CW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_TICKS - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(FIFO_DEPTH);

    logic [CW-1:0]              tick_cnt_q, tick_cnt_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]              fill_q, fill_d;
    logic [AUDIO_BIT_WIDTH-1:0] audio_q, audio_d;
    logic                       tick_dly_q, tick_dly_d;
    logic                       strobe_q, strobe_d;
    logic                       underrun_q, underrun_d;
    logic [AUDIO_BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic tick;
    logic push;
    logic pop;
    logic empty_tick;
    logic ready;

    // The sample tick, the FIFO handshake and the next-state values for all
    // pacer registers.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        ready      = (fill_q < FILL_FULL);
        push       = in_valid & ready;
        pop        = tick & (fill_q != '0);
        empty_tick = tick & (fill_q == '0);

        tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        // The head is read from registered storage only. A sample pushed on
        // an empty tick lands in the FIFO and is played at the following tick.
        audio_d = audio_q;
        if (pop) begin
            audio_d = mem_q[rd_ptr_q];
        end else if (empty_tick && (UNDERRUN_ZERO != 0)) begin
            audio_d = '0;
        end

        // The strobe trails the audio_out update by one cycle, so the sample
        // is already stable when the downstream logic sees the strobe.
        tick_dly_d = tick;
        strobe_d   = tick_dly_q;

        // A clear wins over a set that arrives in the same cycle.
        underrun_d = underrun_q;
        if (underrun_clear) begin
            underrun_d = 1'b0;
        end else if (empty_tick) begin
            underrun_d = 1'b1;
        end
    end

    // Pacer state registers, cleared asynchronously by reset.
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            tick_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            audio_q    <= '0;
            tick_dly_q <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            audio_q    <= audio_d;
            tick_dly_q <= tick_dly_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage. It has no reset because the pointers and the fill level
    // fully define which entries are valid.
    always_ff @(posedge clock_16_934_400) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

`ifdef AUDIO_PACER_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Saturating count of empty ticks. It shares the clear with the sticky flag.
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_clear) begin
            ucnt_d = '0;
        end else if (empty_tick && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    // Underrun statistic register.
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = 16'h0000;
`endif

    assign in_ready      = ready;
    assign audio_out     = audio_q;
    assign sample_strobe = strobe_q;
    assign fill_level    = fill_q;
    assign underrun      = underrun_q;

endmodule
